// File: rtl/goomba_spawner.sv
// goomba_spawner: walks a world-X ordered spawn table and starts goombas
// in free pool slots as the camera scroll approaches each entry.
// Ports: Clk, Reset (sync, active-high), frame_clk (rising edge = frame),
//   level_start (kill all + rewind), scroll_x, slot_alive[N_SLOTS],
//   table_addr / table_data (ROM, 1-cycle latency,
//   {valid, world_x[11:0], spawn_y[9:0]}), start/kill[N_SLOTS] pulses,
//   spawnX/spawnY (valid with start), done (table exhausted).
// Option GOOMBA_SPAWN_DROP_EN: a full pool discards the entry and counts
//   it on drop_cnt; otherwise the entry is retried after the next frame.
module goomba_spawner #(
  parameter int          N_SLOTS      = 4,
  parameter int          ADDR_W       = 6,
  parameter logic [11:0] SPAWN_AHEAD  = 12'd400,
  parameter logic [9:0]  SCREEN_X_OFS = 10'd120
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               level_start,
  input  logic [11:0]        scroll_x,
  input  logic [N_SLOTS-1:0] slot_alive,
  output logic [ADDR_W-1:0]  table_addr,
  input  logic [22:0]        table_data,
  output logic [N_SLOTS-1:0] start,
  output logic [N_SLOTS-1:0] kill,
  output logic [9:0]         spawnX,
  output logic [9:0]         spawnY,
  output logic               done
`ifdef GOOMBA_SPAWN_DROP_EN
  ,
  output logic [7:0]         drop_cnt
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]         state;
  logic [ADDR_W-1:0]  ptr;
  logic [N_SLOTS-1:0] reserved;
  logic [N_SLOTS-1:0] slot_oh;
  logic               frame_clk_d;
  logic               fr_edge;

  logic               e_valid;
  logic [11:0]        e_x;
  logic [9:0]         e_y;
  logic [12:0]        ahead_sum;
  logic [11:0]        ahead_lim;
  logic [N_SLOTS-1:0] free;
  logic [N_SLOTS-1:0] free_lo;
  logic [9:0]         x_calc;
  logic               last;

  assign e_valid = table_data[22];
  assign e_x     = table_data[21:10];
  assign e_y     = table_data[9:0];

  // Look-ahead window edge, clamped so it cannot wrap past the world end.
  assign ahead_sum = {1'b0, scroll_x} + {1'b0, SPAWN_AHEAD};
  assign ahead_lim = ahead_sum[12] ? 12'hFFF : ahead_sum[11:0];

  // Reserved slots were started this frame but may not report alive yet.
  assign free   = ~slot_alive & ~reserved;
  assign x_calc = e_x[9:0] - scroll_x[9:0] + SCREEN_X_OFS;
  assign last   = (ptr == {ADDR_W{1'b1}});

  always_comb begin
    free_lo = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (free[i] && (free_lo == '0)) free_lo[i] = 1'b1;
    end
  end

  assign table_addr = ptr;
  assign start      = (state == S_ISSUE) ? slot_oh : '0;
  assign kill       = (state == S_CLEAR) ? '1 : '0;
  assign done       = (state == S_DONE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      reserved    <= '0;
      slot_oh     <= '0;
      spawnX      <= '0;
      spawnY      <= '0;
      frame_clk_d <= 1'b0;
      fr_edge     <= 1'b0;
`ifdef GOOMBA_SPAWN_DROP_EN
      drop_cnt    <= '0;
`endif
    end else begin
      frame_clk_d <= frame_clk;
      fr_edge     <= frame_clk & ~frame_clk_d;
      if (fr_edge) reserved <= '0;
      if (level_start) begin
        state <= S_CLEAR;
      end else begin
        unique case (state)
          S_IDLE: ;
          S_CLEAR: begin
            ptr      <= '0;
            reserved <= '0;
`ifdef GOOMBA_SPAWN_DROP_EN
            drop_cnt <= '0;
`endif
            state    <= S_FETCH;
          end
          S_FETCH: state <= S_EVAL;
          S_EVAL: begin
            if (!e_valid) begin
              state <= S_DONE;
            end else if (e_x < scroll_x) begin
              if (last) state <= S_DONE;
              else begin
                ptr   <= ptr + ADDR_W'(1);
                state <= S_FETCH;
              end
            end else if (e_x > ahead_lim) begin
              state <= S_WAIT;
            end else if (free != '0) begin
              slot_oh <= free_lo;
              spawnX  <= x_calc;
              spawnY  <= e_y;
              state   <= S_ISSUE;
            end else begin
`ifdef GOOMBA_SPAWN_DROP_EN
              if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
              if (last) state <= S_DONE;
              else begin
                ptr   <= ptr + ADDR_W'(1);
                state <= S_FETCH;
              end
`else
              state <= S_WAIT;
`endif
            end
          end
          S_ISSUE: begin
            reserved <= (fr_edge ? '0 : reserved) | slot_oh;
            if (last) state <= S_DONE;
            else begin
              ptr   <= ptr + ADDR_W'(1);
              state <= S_FETCH;
            end
          end
          S_WAIT: if (fr_edge) state <= S_FETCH;
          S_DONE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
